// File: rtl/dual_core_ram_arbiter.sv
// Round-robin arbiter that lets two cores share one single-port data RAM.
// Grants are combinational, and the RAM is driven in the grant cycle.
// The 1-cycle-latency response (rvalid/err/rdata) is routed back to the
// core that was granted. Addresses beyond the RAM get an error response,
// and cycles where both cores request are counted in a saturating counter.
module dual_core_ram_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [1:0]            req_i,
    input  logic [1:0][31:0]      addr_i,
    input  logic [1:0]            we_i,
    input  logic [1:0][3:0]       be_i,
    input  logic [1:0][31:0]      wdata_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            rvalid_o,
    output logic [1:0]            err_o,
    output logic [1:0][31:0]      rdata_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [3:0]            ram_be_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i,
    output logic [CNT_WIDTH-1:0]  conflict_cnt_o
);

    // The two lowest address bits select a byte within a word; byte lanes
    // are handled by be_i, so these bits are deliberately ignored.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{addr_i[0][1:0], addr_i[1][1:0]};

    logic                 last_q, last_d;   // index of the most recent grant
    logic                 vld_q,  vld_d;    // a response is due this cycle
    logic                 rsel_q, rsel_d;   // port that owns the response
    logic                 oob_q,  oob_d;    // that access was out of range
    logic                 rd_q,   rd_d;     // that access was a read
    logic [CNT_WIDTH-1:0] cnt_q,  cnt_d;

    logic gidx;
    logic granted;
    logic in_range;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Round-robin arbitration: on a tie, the port that did not win last time gets the grant.
    always_comb begin
        gnt_o = 2'b00;
        gidx  = 1'b0;
        unique case (req_i)
            2'b01: begin gnt_o = 2'b01; gidx = 1'b0; end
            2'b10: begin gnt_o = 2'b10; gidx = 1'b1; end
            2'b11: begin
                if (last_q) begin gnt_o = 2'b01; gidx = 1'b0; end
                else        begin gnt_o = 2'b10; gidx = 1'b1; end
            end
            default: ;
        endcase
        granted  = |req_i;
        in_range = (addr_i[gidx][31:ADDR_WIDTH+2] == '0);
    end

    // Drive the RAM from the granted port. Out-of-range accesses never touch the RAM.
    always_comb begin
        ram_en_o    = granted & in_range;
        ram_we_o    = ram_en_o & we_i[gidx];
        ram_addr_o  = '0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (ram_en_o) begin
            ram_addr_o  = addr_i[gidx][ADDR_WIDTH+1:2];
            ram_be_o    = be_i[gidx];
            ram_wdata_o = wdata_i[gidx];
        end
    end

    // Next state: capture response routing at grant time and count contention cycles.
    always_comb begin
        last_d = last_q;
        rsel_d = rsel_q;
        oob_d  = oob_q;
        rd_d   = rd_q;
        vld_d  = granted;
        if (granted) begin
            last_d = gidx;
            rsel_d = gidx;
            oob_d  = ~in_range;
            rd_d   = ~we_i[gidx];
        end
        cnt_d = (req_i == 2'b11) ? sat_inc(cnt_q) : cnt_q;
    end

    // State registers; reset gives port 0 the first tie and drops any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
            vld_q  <= 1'b0;
            rsel_q <= 1'b0;
            oob_q  <= 1'b0;
            rd_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            last_q <= last_d;
            vld_q  <= vld_d;
            rsel_q <= rsel_d;
            oob_q  <= oob_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end

    // Route the response to its owner. Idle lanes read zero, and read data passes only for in-range reads.
    always_comb begin
        rvalid_o = 2'b00;
        err_o    = 2'b00;
        rdata_o  = '0;
        if (vld_q) begin
            rvalid_o[rsel_q] = 1'b1;
            err_o[rsel_q]    = oob_q;
            if (!oob_q && rd_q) rdata_o[rsel_q] = ram_rdata_i;
        end
    end

    assign conflict_cnt_o = cnt_q;

endmodule
